// File: rtl/bram2be_port_arbiter.sv
// Shares one BRAM2BE port between two valid/ready requesters with round-robin grant and
// credit-controlled read-response FIFOs. Define BRAM_ARB_FIXED_PRIORITY_EN for req0 priority.
module bram2be_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int CHUNKSIZE  = 8,
    parameter int WE_WIDTH   = 8,
    parameter int PIPELINED  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [WE_WIDTH-1:0]   req0_be,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [WE_WIDTH-1:0]   req1_be,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  bram_en,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);
    localparam int LAT = 1 + PIPELINED;

    if (WE_WIDTH * CHUNKSIZE != DATA_WIDTH) begin : g_bad_geometry
        $error("WE_WIDTH*CHUNKSIZE must equal DATA_WIDTH");
    end

    logic [1:0]                 req_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0]                 rsp_valid_vec;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][DATA_WIDTH-1:0] req_wdata;
    logic [1:0][DATA_WIDTH-1:0] rsp_data_vec;
    logic [1:0][WE_WIDTH-1:0]   req_be;
    logic [1:0]                 is_write;
    logic [1:0]                 eligible;
    logic [1:0]                 grant;
    logic [1:0]                 rd_grant;
    logic                       sel;
    logic [LAT-1:0]             pipe_vld_reg;
    logic [LAT-1:0]             pipe_id_reg;

    assign req_valid = {req1_valid, req0_valid};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_wdata = {req1_wdata, req0_wdata};
    assign req_be    = {req1_be, req0_be};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_data  = rsp_data_vec[0];
    assign rsp1_data  = rsp_data_vec[1];

    // Per-requester eligibility, credit counter and 2-entry response FIFO
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic [DATA_WIDTH-1:0] mem_reg [2];
        logic                  wr_ptr_reg;
        logic                  rd_ptr_reg;
        logic [1:0]            count_reg;
        logic [1:0]            credit_reg;
        logic                  push;
        logic                  pop;

        assign is_write[gi]      = |req_be[gi];
        assign eligible[gi]      = ~rst & req_valid[gi] & (is_write[gi] | (credit_reg != 2'd0));
        assign rd_grant[gi]      = grant[gi] & ~is_write[gi];
        assign push              = pipe_vld_reg[LAT-1] & (pipe_id_reg[LAT-1] == 1'(gi));
        assign rsp_valid_vec[gi] = ~rst & (count_reg != 2'd0);
        assign rsp_data_vec[gi]  = rsp_valid_vec[gi] ? mem_reg[rd_ptr_reg] : '0;
        assign pop               = rsp_valid_vec[gi] & rsp_ready[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
                count_reg  <= 2'd0;
                credit_reg <= 2'd2;
            end else begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= bram_dout;
                    wr_ptr_reg          <= ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                count_reg  <= count_reg + {1'b0, push} - {1'b0, pop};
                credit_reg <= credit_reg - {1'b0, rd_grant[gi]} + {1'b0, pop};
            end
        end
    end

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant = eligible;
        if (eligible[0]) begin
            grant = 2'b01;
        end
    end
`else
    // last_reg remembers the most recent winner; reset to 1 so req0 wins the first conflict
    logic last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (|grant) begin
            last_reg <= grant[1];
        end
    end

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end
`endif

    assign sel       = grant[1];
    assign bram_en   = |grant;
    assign bram_we   = bram_en ? req_be[sel]    : '0;
    assign bram_addr = bram_en ? req_addr[sel]  : '0;
    assign bram_din  = bram_en ? req_wdata[sel] : '0;

    // Tracks accepted reads until the BRAM returns their data
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_reg <= '0;
            pipe_id_reg  <= '0;
        end else begin
            pipe_vld_reg[0] <= |rd_grant;
            pipe_id_reg[0]  <= sel;
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_id_reg[i]  <= pipe_id_reg[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bram2be_port_arbiter.sv
// Randomised and directed bench for bram2be_port_arbiter against a transaction-level model
// (word memory plus per-requester response queues with due cycles).
module tb_bram2be_port_arbiter;
    localparam int PIPE = 0;
    localparam int L    = 1 + PIPE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req_v;
    logic [1:0][8:0]  req_addr;
    logic [1:0][63:0] req_wd;
    logic [1:0][7:0]  req_be;
    logic [1:0]       rsp_rdy;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_data, rsp1_data;
    logic        bram_en;
    logic [7:0]  bram_we;
    logic [8:0]  bram_addr;
    logic [63:0] bram_din, bram_dout;

    logic [1:0]       rdy, rv;
    logic [1:0][63:0] rspd;
    assign rdy  = {req1_ready, req0_ready};
    assign rv   = {rsp1_valid, rsp0_valid};
    assign rspd = {rsp1_data, rsp0_data};

    bram2be_port_arbiter #(
        .ADDR_WIDTH(9), .DATA_WIDTH(64), .CHUNKSIZE(8), .WE_WIDTH(8), .PIPELINED(PIPE)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_v[0]), .req0_ready(req0_ready), .req0_addr(req_addr[0]),
        .req0_wdata(req_wd[0]), .req0_be(req_be[0]),
        .req1_valid(req_v[1]), .req1_ready(req1_ready), .req1_addr(req_addr[1]),
        .req1_wdata(req_wd[1]), .req1_be(req_be[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp_rdy[0]), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp_rdy[1]), .rsp1_data(rsp1_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // Behavioural BRAM2BE port: read-first, registered output, optional extra stage
    logic [63:0] bram_mem [512];
    logic [63:0] dout_s0, dout_s1;
    always @(posedge clk) begin
        if (bram_en) begin
            dout_s0 <= bram_mem[bram_addr];
            for (int b = 0; b < 8; b++)
                if (bram_we[b]) bram_mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
        end
        dout_s1 <= dout_s0;
    end
    assign bram_dout = (PIPE != 0) ? dout_s1 : dout_s0;

    // Reference model
    typedef struct {
        logic [63:0] data;
        int          due;
    } rsp_t;
    rsp_t        mq [2][$];
    logic [63:0] mmem [512];
    int          cyc;
    logic        last;
    int          n_cmp, n_err;

    logic [1:0]       obs_g, obs_rv;
    logic [1:0][63:0] obs_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] be,
                           input logic [8:0] a, input logic [63:0] d);
        req_v[r] = v; req_be[r] = be; req_addr[r] = a; req_wd[r] = d;
    endtask

    task automatic idle();
        req_v = 2'b00; req_be = '0; req_addr = '0; req_wd = '0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return after the edge
    task automatic step();
        logic [1:0] wr, elig, g, ev;
        int   s;
        rsp_t e;
        @(negedge clk);
        obs_g = rdy; obs_rv = rv; obs_rd = rspd;
        if (rst) begin
            check("rst_ready", 64'(rdy), 64'd0);
            check("rst_rsp_valid", 64'(rv), 64'd0);
            check("rst_rsp0_data", rsp0_data, 64'd0);
            check("rst_rsp1_data", rsp1_data, 64'd0);
            check("rst_bram_en", 64'(bram_en), 64'd0);
            check("rst_bram_we", 64'(bram_we), 64'd0);
            check("rst_bram_addr", 64'(bram_addr), 64'd0);
            check("rst_bram_din", bram_din, 64'd0);
            mq[0].delete(); mq[1].delete();
            last = 1'b1;
        end else begin
            for (int r = 0; r < 2; r++) begin
                wr[r]   = |req_be[r];
                elig[r] = req_v[r] && (wr[r] || mq[r].size() < 2);
            end
            g = elig;
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
            if (elig[0]) g = 2'b01;
`else
            if (elig == 2'b11) g = last ? 2'b01 : 2'b10;
`endif
            check("ready", 64'(rdy), 64'(g));
            s = int'(g[1]);
            check("bram_en", 64'(bram_en), 64'(|g));
            check("bram_we", 64'(bram_we), (g != 0) ? 64'(req_be[s]) : 64'd0);
            check("bram_addr", 64'(bram_addr), (g != 0) ? 64'(req_addr[s]) : 64'd0);
            check("bram_din", bram_din, (g != 0) ? req_wd[s] : 64'd0);
            for (int r = 0; r < 2; r++) begin
                ev[r] = (mq[r].size() > 0) && (mq[r][0].due <= cyc);
                check($sformatf("rsp%0d_valid", r), 64'(rv[r]), 64'(ev[r]));
                if (ev[r]) check($sformatf("rsp%0d_data", r), rspd[r], mq[r][0].data);
            end
            for (int r = 0; r < 2; r++)
                if (ev[r] && rsp_rdy[r]) void'(mq[r].pop_front());
            if (g != 0) begin
                last = g[1];
                if (wr[s]) begin
                    for (int b = 0; b < 8; b++)
                        if (req_be[s][b]) mmem[req_addr[s]][b*8 +: 8] = req_wd[s][b*8 +: 8];
                end else begin
                    e.data = mmem[req_addr[s]];
                    e.due  = cyc + 1 + L;
                    mq[s].push_back(e);
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int r, output logic [63:0] d, output int lat);
        lat = -1;
        d   = '0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (obs_rv[r]) begin
                lat = k;
                d   = obs_rd[r];
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [63:0] d;
        int lat, g0, g1, c0, c1, cnt;
        n_cmp = 0; n_err = 0; cyc = 0; last = 1'b1;
        for (int i = 0; i < 512; i++) begin
            bram_mem[i] = '0;
            mmem[i]     = '0;
        end
        rst = 1'b1; idle(); rsp_rdy = 2'b11;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // 1: full write then read back
        set_req(0, 1'b1, 8'hFF, 9'd5, 64'h1122334455667788); step();
        set_req(0, 1'b1, 8'h00, 9'd5, 64'd0); step();
        idle(); wait_rsp(0, d, lat);
        check("t1_latency", 64'(lat), 64'(1 + L));
        check("t1_data", d, 64'h1122334455667788);

        // 2: partial byte-enable write
        set_req(0, 1'b1, 8'hFF, 9'd3, 64'hCCCCCCCC_DDDDDDDD); step();
        set_req(0, 1'b1, 8'h0F, 9'd3, 64'hAAAAAAAA_BBBBBBBB); step();
        set_req(0, 1'b1, 8'h00, 9'd3, 64'd0); step();
        idle(); wait_rsp(0, d, lat);
        check("t2_data", d, 64'hCCCCCCCC_BBBBBBBB);

        // 3: both read continuously, grants alternate starting with req0
        for (int k = 0; k < 16; k++) begin
            set_req(0, 1'b1, 8'hFF, 9'(64 + k), {32'(64 + k), 32'hD0D0D0D0}); step();
        end
        idle(); rst = 1'b1; step(); rst = 1'b0;
        g0 = 0; g1 = 0; c0 = 0; c1 = 0;
        for (int c = 0; c < 12; c++) begin
            set_req(0, c < 8, 8'h00, 9'(64 + g0), 64'd0);
            set_req(1, c < 8, 8'h00, 9'(72 + g1), 64'd0);
            step();
            if (c < 8) check("t3_grant", 64'(obs_g), (c % 2 == 0) ? 64'd1 : 64'd2);
            if (obs_g[0]) g0++;
            if (obs_g[1]) g1++;
            if (obs_rv[0]) c0++;
            if (obs_rv[1]) c1++;
        end
        check("t3_rsp0_count", 64'(c0), 64'd4);
        check("t3_rsp1_count", 64'(c1), 64'd4);

        // 4: req0 backpressured, credits limit it to 2 outstanding reads
        idle(); rsp_rdy = 2'b10; g0 = 0; g1 = 0;
        for (int c = 0; c < 20; c++) begin
            set_req(0, g0 < 4, 8'h00, 9'(64 + g0), 64'd0);
            set_req(1, c < 12, 8'h00, 9'(72 + (c % 8)), 64'd0);
            rsp_rdy[0] = (c >= 8);
            step();
            if (obs_g[0]) g0++;
            if (obs_g[1] && c < 8) g1++;
            if (c == 7) begin
                check("t4_req0_accepted", 64'(g0), 64'd2);
                check("t4_req0_ready_low", 64'(obs_g[0]), 64'd0);
                check("t4_req1_progress", 64'(g1 >= 3), 64'd1);
            end
        end
        check("t4_req0_total", 64'(g0), 64'd4);

        // 5: reset right after a read grant drops the in-flight read
        idle(); rsp_rdy = 2'b11;
        for (int k = 0; k < 4; k++) step();
        set_req(0, 1'b1, 8'h00, 9'd5, 64'd0); step();
        set_req(1, 1'b1, 8'hFF, 9'd9, 64'h5A5A5A5A5A5A5A5A);
        rst = 1'b1; step(); rst = 1'b0;
        idle(); cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_rv != 2'b00) cnt++;
        end
        check("t5_no_rsp_after_reset", 64'(cnt), 64'd0);
        rsp_rdy[0] = 1'b0; g0 = 0;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 8'h00, 9'(k), 64'd0); step();
            if (obs_g[0]) g0++;
        end
        check("t5_credits", 64'(g0), 64'd2);
        idle(); rsp_rdy = 2'b11;
        for (int k = 0; k < 6; k++) step();

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
        // 6: fixed priority keeps req1 out while req0 writes continuously
        for (int k = 0; k < 5; k++) begin
            set_req(0, 1'b1, 8'hFF, 9'd1, 64'(k));
            set_req(1, 1'b1, 8'hFF, 9'd2, 64'(k + 100));
            step();
            check("t6_req1_blocked", 64'(obs_g[1]), 64'd0);
        end
        req_v[0] = 1'b0; step();
        check("t6_req1_served", 64'(obs_g[1]), 64'd1);
        idle();
`endif

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int r = 0; r < 2; r++) begin
                req_v[r]    = ($urandom_range(0, 3) != 0);
                req_be[r]   = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
                req_addr[r] = 9'($urandom_range(0, 15));
                req_wd[r]   = {$urandom, $urandom};
                rsp_rdy[r]  = ($urandom_range(0, 9) < 7);
            end
            step();
        end
        rst = 1'b0; idle(); rsp_rdy = 2'b11;
        for (int k = 0; k < 8; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
